// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared constants and sizing helpers for the debouncer
package button_debouncer_pkg;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit synchronizer, stability counter and debounced output
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int          p_SYNC_STAGES  = 2,
  parameter int          p_STABLE_CYCLES = 50000,
  parameter logic [0:0]  p_IDLE_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic changed,
  output logic busy
);
  localparam int CW = cnt_width(p_STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(p_STABLE_CYCLES - 1);
  logic [p_SYNC_STAGES-1:0] sync = {p_SYNC_STAGES{p_IDLE_LEVEL}};
  logic [CW-1:0] cnt = '0;
  logic lvl = p_IDLE_LEVEL;
  logic chg = 1'b0;
  logic synced;
  assign synced = sync[p_SYNC_STAGES-1];
  assign level = lvl;
  assign changed = chg;
  assign busy = |cnt;
  // shift the raw input through the synchronizer and accept a level only after it has held for the full count
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {p_SYNC_STAGES{p_IDLE_LEVEL}};
      cnt <= '0;
      lvl <= p_IDLE_LEVEL;
      chg <= 1'b0;
    end else begin
      sync <= {sync[p_SYNC_STAGES-2:0], raw};
      chg <= 1'b0;
      if (synced == lvl) cnt <= '0;
      else if (cnt == LAST) begin
        lvl <= synced;
        cnt <= '0;
        chg <= 1'b1;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: array of independent debounce channels for raw button/switch inputs
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int          p_WIDTH         = 1,
  parameter int          p_SYNC_STAGES   = 2,
  parameter int          p_STABLE_CYCLES = 50000,
  parameter logic [0:0]  p_IDLE_LEVEL    = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_WIDTH-1:0] iv_input,
  output logic [p_WIDTH-1:0] ov_output,
  output logic [p_WIDTH-1:0] ov_changed,
  output logic [p_WIDTH-1:0] ov_busy
);
  for (genvar i = 0; i < p_WIDTH; i++) begin : g_ch
    debounce_channel #(
      .p_SYNC_STAGES(p_SYNC_STAGES),
      .p_STABLE_CYCLES(p_STABLE_CYCLES),
      .p_IDLE_LEVEL(p_IDLE_LEVEL)
    ) u_ch (
      .clk(i_clk),
      .rst(i_rst),
      .raw(iv_input[i]),
      .level(ov_output[i]),
      .changed(ov_changed[i]),
      .busy(ov_busy[i])
    );
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: table, directed and random checks of two debouncer configurations
module tb_button_debouncer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;
  logic [3:0] in_a = 4'h0;
  logic [3:0] out_a, chg_a, busy_a;
  logic [1:0] in_b = 2'b11;
  logic [1:0] out_b, chg_b, busy_b;
  int total = 0;
  int bad = 0;
  button_debouncer #(.p_WIDTH(4), .p_SYNC_STAGES(2), .p_STABLE_CYCLES(4), .p_IDLE_LEVEL(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst), .iv_input(in_a),
    .ov_output(out_a), .ov_changed(chg_a), .ov_busy(busy_a));
  button_debouncer #(.p_WIDTH(2), .p_SYNC_STAGES(2), .p_STABLE_CYCLES(1), .p_IDLE_LEVEL(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .iv_input(in_b),
    .ov_output(out_b), .ov_changed(chg_b), .ov_busy(busy_b));
  int s_of[2] = '{2, 2};
  int n_of[2] = '{4, 1};
  bit idle_of[2] = '{1'b0, 1'b1};
  bit [3:0] hist[2][16];
  bit [3:0] mout[2] = '{4'h0, 4'hf};
  bit [3:0] mchg[2] = '{4'h0, 4'h0};
  bit [3:0] mbusy[2] = '{4'h0, 4'h0};
  typedef struct {
    bit r;
    logic [3:0] a;
    logic [3:0] out;
    logic [3:0] chg;
    logic [3:0] busy;
  } vec_t;
  vec_t tbl[9];
  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // a level is accepted once the last N synced samples all differ from the current output
  task automatic model_step(input int d, input bit r, input bit [3:0] in);
    bit acc;
    bit [3:0] syn;
    if (r) begin
      for (int i = 0; i < 16; i++) hist[d][i] = {4{idle_of[d]}};
      mout[d] = {4{idle_of[d]}};
      mchg[d] = 4'h0;
      mbusy[d] = 4'h0;
    end else begin
      mchg[d] = 4'h0;
      mbusy[d] = 4'h0;
      syn = hist[d][s_of[d]-1];
      for (int c = 0; c < 4; c++) begin
        acc = 1'b1;
        for (int j = 0; j < n_of[d]; j++)
          if (hist[d][s_of[d]-1+j][c] == mout[d][c]) acc = 1'b0;
        if (syn[c] != mout[d][c]) begin
          if (acc) begin
            mout[d][c] = ~mout[d][c];
            mchg[d][c] = 1'b1;
          end else mbusy[d][c] = 1'b1;
        end
      end
      for (int i = 15; i > 0; i--) hist[d][i] = hist[d][i-1];
      hist[d][0] = in;
    end
  endtask
  task automatic cyc(input bit r, input logic [3:0] a, input logic [1:0] b);
    rst = r;
    in_a = a;
    in_b = b;
    @(posedge clk);
    model_step(0, r, a);
    model_step(1, r, {2'b00, b});
    #1;
    check("model_out_a", out_a, mout[0]);
    check("model_chg_a", chg_a, mchg[0]);
    check("model_busy_a", busy_a, mbusy[0]);
    check("model_out_b", {2'b00, out_b}, mout[1] & 4'h3);
    check("model_chg_b", {2'b00, chg_b}, mchg[1] & 4'h3);
    check("model_busy_b", {2'b00, busy_b}, mbusy[1] & 4'h3);
  endtask
  initial begin
    logic [3:0] a;
    logic [1:0] b;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) hist[d][i] = {4{idle_of[d]}};
    #1;
    check("powerup_out_a", out_a, 4'h0);
    check("powerup_out_b", {2'b00, out_b}, 4'h3);
    check("powerup_chg_a", chg_a, 4'h0);
    tbl[0] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[2] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[3] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h1};
    tbl[4] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h1};
    tbl[5] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h1};
    tbl[6] = '{1'b0, 4'h1, 4'h1, 4'h1, 4'h0};
    tbl[7] = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[8] = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0};
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].r, tbl[i].a, 2'b11);
      check("tbl_out", out_a, tbl[i].out);
      check("tbl_chg", chg_a, tbl[i].chg);
      check("tbl_busy", busy_a, tbl[i].busy);
    end
    cyc(1'b1, 4'h0, 2'b11);
    for (int k = 0; k < 11; k++) begin
      cyc(1'b0, (k == 3) ? 4'h0 : 4'h1, 2'b00);
      if (k == 1) check("fast_b_hold", {2'b00, out_b}, 4'h3);
      if (k == 2) begin
        check("fast_b_step", {2'b00, out_b}, 4'h0);
        check("fast_b_pulse", {2'b00, chg_b}, 4'h3);
      end
      if (k == 3) check("fast_b_pulse_end", {2'b00, chg_b}, 4'h0);
      if (k == 8) check("glitch_hold", out_a, 4'h0);
      if (k == 9) begin
        check("glitch_rise", out_a, 4'h1);
        check("glitch_pulse", chg_a, 4'h1);
      end
    end
    cyc(1'b1, 4'h0, 2'b11);
    for (int k = 0; k < 25; k++) begin
      a = {1'b1, 1'b0, ((k / 2) % 2 == 0) ? 1'b1 : 1'b0, 1'b1};
      cyc(1'b0, a, 2'b11);
      check("bounce_ch1", {3'b000, out_a[1]}, 4'h0);
      if (k == 4) check("multi_before", out_a, 4'h0);
      if (k == 5) begin
        check("multi_out", out_a, 4'h9);
        check("multi_chg", chg_a, 4'h9);
      end
    end
    cyc(1'b1, 4'h0, 2'b11);
    for (int k = 0; k < 11; k++) begin
      cyc(k == 3, 4'h1, 2'b11);
      if (k < 9) check("rst_no_pulse", chg_a, 4'h0);
      if (k == 3 || k == 8) check("rst_out_low", out_a, 4'h0);
      if (k == 9) begin
        check("rst_restart_out", out_a, 4'h1);
        check("rst_restart_chg", chg_a, 4'h1);
      end
    end
    a = 4'h0;
    b = 2'b11;
    cyc(1'b1, a, b);
    for (int k = 0; k < 3000; k++) begin
      a = a ^ 4'($urandom & $urandom);
      b = b ^ 2'($urandom & $urandom);
      cyc($urandom_range(0, 299) == 0, a, b);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter p_WIDTH, default 1, giving the number of independent input channels.
REQ-002 The block SHALL have parameter p_SYNC_STAGES, default 2, giving the synchronizer depth (legal range 2..4).
REQ-003 The block SHALL have parameter p_STABLE_CYCLES, default 50000, giving the clock cycles a changed level must persist before it is accepted (legal minimum 1).
REQ-004 The block SHALL have parameter p_IDLE_LEVEL [0:0], default 1'b0, giving the debounced level of every channel after reset.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port iv_input, input, p_WIDTH bits: raw asynchronous, bouncing inputs such as buttons and switches.
REQ-008 The block SHALL have port ov_output, output, p_WIDTH bits: registered, debounced level per channel, intended to drive the rise/fall edge-detection stage directly.
REQ-009 The block SHALL have port ov_changed, output, p_WIDTH bits: registered pulse, high for exactly one cycle when the corresponding ov_output bit changes.
REQ-010 The block SHALL have port ov_busy, output, p_WIDTH bits: combinational, high while the corresponding channel's stability counter is non-zero.

Function
REQ-011 Each channel SHALL pass iv_input through a p_SYNC_STAGES-deep flip-flop chain; only the last stage (the synced value) SHALL feed the decision logic.
REQ-012 Each channel SHALL have a counter of width max(1, clog2(p_STABLE_CYCLES)) that never exceeds p_STABLE_CYCLES-1.
REQ-013 On each edge where the synced value equals ov_output, the counter SHALL clear to 0 and ov_output SHALL hold.
REQ-014 On each edge where the synced value differs from ov_output and counter < p_STABLE_CYCLES-1, the counter SHALL increment.
REQ-015 On each edge where the synced value differs from ov_output and counter == p_STABLE_CYCLES-1, ov_output SHALL take the synced value, the counter SHALL clear, and ov_changed SHALL be 1 for that cycle.
REQ-016 ov_changed SHALL be 0 on every other cycle.
REQ-017 Latency: if a new level is first sampled into the synchronizer on edge 0 and is held, ov_output SHALL change on edge p_SYNC_STAGES+p_STABLE_CYCLES-1.
REQ-018 Any bounce back to the current ov_output level before acceptance SHALL restart the count from 0, with no partial credit.
REQ-019 The count SHALL never wrap around.
REQ-020 With p_STABLE_CYCLES=1, ov_output SHALL follow the synced value with zero extra delay.
REQ-021 Channels SHALL be fully independent: simultaneous changes on several channels SHALL each follow REQ-013..REQ-018 with no interaction.

Reset
REQ-022 While i_rst=1 at a clock edge, every synchronizer stage and every ov_output bit SHALL load p_IDLE_LEVEL, all counters SHALL load 0, and ov_changed SHALL load 0.
REQ-023 Power-up register initial values SHALL equal the reset values.
REQ-024 Reset asserted mid-count SHALL discard the pending change, with no ov_changed pulse.
REQ-025 After reset deasserts, counting SHALL resume per REQ-011..REQ-018 from the first edge with i_rst=0.

Structure
REQ-026 The counter-width helper (clog2 with a minimum of 1) SHALL live in the shared library constants/functions include; no other shared typedefs are needed.
REQ-027 Per-bit logic SHALL be a sub-module debounce_channel, containing the synchronizer, counter, output register and changed register, instantiated p_WIDTH times via generate.

Verification
REQ-028 With p_WIDTH=1, p_SYNC_STAGES=2, p_STABLE_CYCLES=4: step iv_input 0->1, sampled on edge 0 -> ov_output=1 and ov_changed=1 on edge 5 only; ov_busy high on edges 2..4.
REQ-029 Same configuration: drive 1 for 3 cycles, then 0, then 1 held -> no output change during the glitch; ov_output rises 5 edges after the final 1 is sampled.
REQ-030 With p_WIDTH=4: apply channels 0 and 3 rising on the same edge while channel 1 bounces every 2 cycles -> channels 0 and 3 change together on edge 5; channel 1 never changes.
REQ-031 Assert i_rst for one cycle on edge 3 of a pending 0->1 change -> ov_output=0, ov_changed never pulses, and the counter restarts so the output rises at edge 3+1+5 if the input is held.
REQ-032 With p_IDLE_LEVEL=1 and p_STABLE_CYCLES=1 -> ov_output=1 after reset; an input step to 0 appears on edge 2 with a single ov_changed pulse.
